// File: rtl/atari_bus_bridge.sv
// Atari 7800 cartridge bus bridge: synchronises the cart bus and serves ROM reads through a 3-clk fetch FSM.
// Optional SuperGame-style banking is compiled in with `define BANKSWITCH_EN.
module atari_bus_bridge #(
  parameter logic [15:0] ROM_BASE    = 16'h4000,
  parameter int          ROM_DEPTH   = 49152,
  parameter int          ADDR_W      = 17,
  parameter int          BANK_BITS   = 3,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          a,
  input  logic [7:0]           d_in,
  output logic [7:0]           d_out,
  output logic                 d_oe,
  input  logic                 phi2,
  input  logic                 rw,
  input  logic                 halt,
  output logic                 buf_dir,
  output logic                 buf_oe,
  output logic [ADDR_W-1:0]    rom_addr,
  output logic                 rom_rd,
  input  logic [7:0]           rom_data,
  output logic [BANK_BITS-1:0] bank,
  output logic                 act
);

  // Packed as {a, d, phi2, rw, halt}; reset value leaves the bus idle (no read window).
  localparam logic [26:0] SYNC_RST = {16'h0000, 8'h00, 1'b0, 1'b1, 1'b1};

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRIVE} state_t;

  logic [26:0] sync_reg [SYNC_STAGES];
  logic [15:0] a_s;
  logic [7:0]  d_s;
  logic        phi2_s, rw_s, halt_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= SYNC_RST;
    end else begin
      sync_reg[0] <= {a, d_in, phi2, rw, halt};
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  assign {a_s, d_s, phi2_s, rw_s, halt_s} = sync_reg[SYNC_STAGES-1];

  logic        decoded;
  logic [31:0] idx;
  logic        in_range;
  logic        want;
  logic        unused_bits;

`ifdef BANKSWITCH_EN
  logic [BANK_BITS-1:0] bank_reg;
  logic                 phi2_d_reg;

  // Bank latches on the phi2 falling edge of a CPU write into the switchable window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_reg   <= '0;
      phi2_d_reg <= 1'b0;
    end else begin
      phi2_d_reg <= phi2_s;
      if (phi2_d_reg && !phi2_s && halt_s && !rw_s && a_s[15:14] == 2'b10)
        bank_reg <= d_s[BANK_BITS-1:0];
    end
  end

  always_comb begin
    decoded = a_s[15];
    if (a_s[14]) idx = (32'({BANK_BITS{1'b1}}) << 14) | 32'(a_s[13:0]);
    else         idx = (32'(bank_reg) << 14) | 32'(a_s[13:0]);
  end

  assign bank        = bank_reg;
  assign unused_bits = ^{d_s, ROM_BASE};
`else
  always_comb begin
    decoded = (a_s >= ROM_BASE);
    idx     = 32'(a_s - ROM_BASE);
  end

  assign bank        = '0;
  assign unused_bits = ^d_s;
`endif

  assign in_range = (idx < 32'(ROM_DEPTH));
  assign want     = decoded & rw_s & ((phi2_s & halt_s) | !halt_s);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   rom_addr_reg, rom_addr_next;
  logic                rom_rd_reg, rom_rd_next;
  logic [7:0]          d_out_reg, d_out_next;
  logic                d_oe_reg, d_oe_next;
  logic                buf_oe_reg, buf_oe_next;
  logic                buf_dir_reg, buf_dir_next;
  logic                act_reg, act_next;
  logic                ok_reg, ok_next;
  logic [15:0]         a_lat_reg, a_lat_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rom_addr_reg <= '0;
      rom_rd_reg   <= 1'b0;
      d_out_reg    <= 8'hFF;
      d_oe_reg     <= 1'b0;
      buf_oe_reg   <= 1'b1;
      buf_dir_reg  <= 1'b1;
      act_reg      <= 1'b0;
      ok_reg       <= 1'b0;
      a_lat_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      rom_addr_reg <= rom_addr_next;
      rom_rd_reg   <= rom_rd_next;
      d_out_reg    <= d_out_next;
      d_oe_reg     <= d_oe_next;
      buf_oe_reg   <= buf_oe_next;
      buf_dir_reg  <= buf_dir_next;
      act_reg      <= act_next;
      ok_reg       <= ok_next;
      a_lat_reg    <= a_lat_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    rom_addr_next = rom_addr_reg;
    rom_rd_next   = 1'b0;
    d_out_next    = d_out_reg;
    d_oe_next     = d_oe_reg;
    buf_oe_next   = buf_oe_reg;
    act_next      = 1'b0;
    ok_next       = ok_reg;
    a_lat_next    = a_lat_reg;
    // Direction may only move while the buffer is disabled and we are not driving.
    buf_dir_next  = (buf_oe_reg && !d_oe_reg) ? rw_s : buf_dir_reg;

    if (!want) begin
      state_next  = IDLE;
      d_oe_next   = 1'b0;
      buf_oe_next = 1'b1;
    end else begin
      case (state_reg)
        IDLE, DRIVE: begin
          // A DRIVE re-fetch keeps d_oe/buf_oe and the old byte until WAIT replaces it.
          if (state_reg == IDLE || a_s != a_lat_reg) begin
            state_next    = FETCH;
            rom_rd_next   = in_range;
            rom_addr_next = idx[ADDR_W-1:0];
            ok_next       = in_range;
            a_lat_next    = a_s;
          end
        end
        FETCH: state_next = WAIT;
        WAIT: begin
          state_next  = DRIVE;
          d_out_next  = ok_reg ? rom_data : 8'hFF;
          d_oe_next   = 1'b1;
          buf_oe_next = 1'b0;
          act_next    = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign rom_addr = rom_addr_reg;
  assign rom_rd   = rom_rd_reg;
  assign d_out    = d_out_reg;
  assign d_oe     = d_oe_reg;
  assign buf_oe   = buf_oe_reg;
  assign buf_dir  = buf_dir_reg;
  assign act      = act_reg;

endmodule

// File: tb/tb_atari_bus_bridge.sv
// Randomised bench for atari_bus_bridge against an address-map/ROM reference model.
module tb_atari_bus_bridge;

`ifdef BANKSWITCH_EN
  localparam int          DEPTH = 98304;
  localparam logic [15:0] BASE  = 16'h8000;
`else
  localparam int          DEPTH = 1024;
  localparam logic [15:0] BASE  = 16'h4000;
`endif
  localparam int LAT = 2 + 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a;
  logic [7:0]  d_in, d_out, rom_data;
  logic        d_oe, phi2, rw, halt, buf_dir, buf_oe, rom_rd, act;
  logic [16:0] rom_addr;
  logic [2:0]  bank;

  logic [7:0]  mem [131072];
  int          n_tests, n_fail, model_bank;

  atari_bus_bridge #(.ROM_BASE(16'h4000), .ROM_DEPTH(DEPTH), .ADDR_W(17),
                     .BANK_BITS(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
    .phi2(phi2), .rw(rw), .halt(halt), .buf_dir(buf_dir), .buf_oe(buf_oe),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data), .bank(bank), .act(act)
  );

  always #5 clk = ~clk;

  // ROM: data valid one clk after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (rom_rd) rom_data <= mem[rom_addr];
    else        rom_data <= 8'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_idx(input logic [15:0] addr);
`ifdef BANKSWITCH_EN
    if (addr < 16'h8000) return -1;
    if (addr >= 16'hC000) return 7 * 16384 + int'(addr) - 16'hC000;
    return model_bank * 16384 + int'(addr) - 16'h8000;
`else
    if (addr < 16'h4000) return -1;
    return int'(addr) - 16'h4000;
`endif
  endfunction

  function automatic logic [7:0] model_data(input int idx);
    return (idx < DEPTH) ? mem[idx] : 8'hFF;
  endfunction

  task automatic bus_idle();
    @(negedge clk);
    a = 16'h0000; phi2 = 1'b0; rw = 1'b1; halt = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_oe", d_oe, 0);
    check("idle_buf_oe", buf_oe, 1);
  endtask

  task automatic do_read(input logic [15:0] addr, input logic dma);
    int idx, first_oe, acts, rds;
    idx = model_idx(addr);
    first_oe = 0; acts = 0; rds = 0;
    @(negedge clk);
    a = addr; rw = 1'b1;
    if (dma) begin halt = 1'b0; phi2 = 1'b0; end
    else     begin halt = 1'b1; phi2 = 1'b1; end
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (d_oe && first_oe == 0) first_oe = cyc;
      acts += int'(act);
      rds  += int'(rom_rd);
    end
    if (idx < 0) begin
      check("nodec_oe", first_oe, 0);
      check("nodec_rd", rds, 0);
    end else begin
      check("rd_latency", first_oe, LAT);
      check("rd_act", acts, 1);
      check("rd_strobes", rds, (idx < DEPTH) ? 1 : 0);
      check("rd_addr", rom_addr, idx);
      check("rd_data", d_out, model_data(idx));
      check("rd_buf_oe", buf_oe, 0);
      check("rd_buf_dir", buf_dir, 1);
    end
    $display("[TB] read a=%04h dma=%0d idx=%0d d_out=%02h d_oe=%0d", addr, dma, idx, d_out, d_oe);
    bus_idle();
  endtask

  task automatic do_write(input logic [7:0] val);
    int oe_seen;
    oe_seen = 0;
    @(negedge clk);
    a = 16'h8000 | 16'($urandom_range(0, 16'h3FFF)); d_in = val; rw = 1'b0; halt = 1'b1; phi2 = 1'b1;
    repeat (4) begin @(negedge clk); oe_seen += int'(d_oe); end
    phi2 = 1'b0;
    repeat (4) begin @(negedge clk); oe_seen += int'(d_oe); end
`ifdef BANKSWITCH_EN
    model_bank = int'(val[2:0]);
`endif
    check("wr_no_drive", oe_seen, 0);
    check("wr_bank", bank, model_bank);
    $display("[TB] write a=%04h d=%02h bank=%0d", a, val, bank);
    a = 16'h0000; rw = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic burst_test();
    logic [7:0] prev, cur;
    int drops, glitches, started;
    drops = 0; glitches = 0; started = 0; prev = 8'hFF;
    @(negedge clk);
    halt = 1'b0; phi2 = 1'b0; rw = 1'b1;
    for (int step = 0; step < 4; step++) begin
      a = BASE + 16'(step);
      cur = model_data(model_idx(a));
      for (int cyc = 0; cyc < 8; cyc++) begin
        @(negedge clk);
        if (started != 0 && !d_oe) drops++;
        if (started != 0 && d_out !== cur && d_out !== prev) glitches++;
        if (d_oe) started = 1;
      end
      check("burst_data", d_out, cur);
      $display("[TB] burst a=%04h d_out=%02h d_oe=%0d", a, d_out, d_oe);
      prev = cur;
    end
    check("burst_drops", drops, 0);
    check("burst_glitch", glitches, 0);
    bus_idle();
  endtask

  task automatic release_test();
    @(negedge clk);
    a = BASE; rw = 1'b1; halt = 1'b1; phi2 = 1'b1;
    repeat (6) @(negedge clk);
    check("rel_pre_oe", d_oe, 1);
    rw = 1'b0;
    repeat (2) @(negedge clk);
    check("rel_hold_oe", d_oe, 1);
    @(negedge clk);
    check("rel_oe", d_oe, 0);
    check("rel_buf_oe", buf_oe, 1);
    check("rel_dir_held", buf_dir, 1);
    @(negedge clk);
    check("rel_dir_after", buf_dir, 0);
    $display("[TB] release d_oe=%0d buf_oe=%0d buf_dir=%0d", d_oe, buf_oe, buf_dir);
    bus_idle();
  endtask

  task automatic reset_test();
    int first_oe;
    first_oe = 0;
    @(negedge clk);
    a = BASE; rw = 1'b1; halt = 1'b1; phi2 = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_pre_oe", d_oe, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_oe", d_oe, 0);
    check("rst_buf_oe", buf_oe, 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_bank = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (d_oe && first_oe == 0) first_oe = cyc;
    end
    check("rst_latency", first_oe, LAT);
    check("rst_bank", bank, 0);
    check("rst_data", d_out, model_data(model_idx(BASE)));
    $display("[TB] reset-in-drive first_oe=%0d d_out=%02h", first_oe, d_out);
    bus_idle();
  endtask

  initial begin
    n_tests = 0; n_fail = 0; model_bank = 0;
    for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA5;
    for (int i = 1; i < 131072; i++) if (mem[i] == mem[i-1]) mem[i] = mem[i] ^ 8'h01;

    rst_n = 1'b0; a = 16'h0000; d_in = 8'h00; phi2 = 1'b0; rw = 1'b1; halt = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_d_oe", d_oe, 0);
    check("reset_buf_oe", buf_oe, 1);
    check("reset_buf_dir", buf_dir, 1);
    check("reset_rom_rd", rom_rd, 0);
    check("reset_act", act, 0);
    check("reset_d_out", d_out, 8'hFF);
    check("reset_bank", bank, 0);
    $display("[TB] reset d_oe=%0d buf_oe=%0d d_out=%02h", d_oe, buf_oe, d_out);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_read(BASE, 1'b0);
`ifdef BANKSWITCH_EN
    do_write(8'h05);
    do_read(16'h8010, 1'b0);
    do_read(16'hC000, 1'b0);
    do_read(16'h7FFF, 1'b0);
`else
    do_read(16'h4400, 1'b0);
    do_read(16'h3FFF, 1'b0);
    do_write(8'h05);
`endif
    burst_test();
    release_test();
    reset_test();

    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_write(8'($urandom));
      end else begin
`ifdef BANKSWITCH_EN
        do_read(16'($urandom_range(16'h7F00, 16'hFFFF)), 1'($urandom_range(0, 1)));
`else
        do_read(16'($urandom_range(16'h3F00, 16'h47FF)), 1'($urandom_range(0, 1)));
`endif
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/atari_bus_bridge.md
ATARI_BUS_BRIDGE -- requirements
Module: atari_bus_bridge

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ROM_BASE, 16'h4000, lowest decoded cart address.
- ROM_DEPTH, 49152, ROM bytes present.
- ADDR_W, 17, rom_addr width.
- BANK_BITS, 3, bank register width.
- SYNC_STAGES, 2, input synchroniser depth, >=2.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, 27 MHz system clock, sole clock.
- rst_n, in, 1, synchronous active-low reset.
- a, in, 16, Atari address bus.
- d_in, in, 8, data bus input.
- d_out, out, 8, data to drive.
- d_oe, out, 1, FPGA tristate enable, active high.
- phi2, in, 1, Phase 2 clock.
- rw, in, 1, 1 = read.
- halt, in, 1, low = Maria DMA.
- buf_dir, out, 1, level-shifter direction, 1 = cart-to-Atari.
- buf_oe, out, 1, buffer enable, active low.
- rom_addr, out, ADDR_W, ROM byte index.
- rom_rd, out, 1, ROM read strobe.
- rom_data, in, 8, ROM data, valid 1 clk after rom_rd.
- bank, out, BANK_BITS, current bank.
- act, out, 1, 1-clk pulse per new drive (LED).

Function
REQ-003 a, d_in, phi2, rw, halt SHALL pass through SYNC_STAGES flops; all decisions SHALL use final-stage (_s) values only.
REQ-004 Window signals:
- cpu_win = phi2_s & halt_s.
- dma_win = !halt_s.
- want = decoded & rw_s & (cpu_win | dma_win).
REQ-005 FSM states SHALL be IDLE, FETCH, WAIT, DRIVE.
REQ-006 IDLE -> FETCH when want; FETCH asserts rom_rd for exactly 1 clk with rom_addr registered.
REQ-007 WAIT SHALL capture rom_data into d_out, then go to DRIVE; read latency from want to d_oe=1 SHALL be 3 clks.
REQ-008 In DRIVE: d_oe=1, buf_oe=0, act pulses on the entry clk only.
REQ-009 In DRIVE, if want persists and a_s changes, go to FETCH with d_oe/buf_oe held and old d_out kept until new data is captured (DMA burst).
REQ-010 From any state, !want SHALL give IDLE with d_oe=0 and buf_oe=1 on the next clk, even mid-fetch; the pending rom_data is discarded.
REQ-011 buf_dir SHALL follow rw_s only while buf_oe=1 and d_oe=0, and SHALL never change while the buffer is enabled.
REQ-012 If the computed index is >= ROM_DEPTH, rom_rd SHALL stay 0 and d_out SHALL be 8'hFF, with timing unchanged.
REQ-013 Without bank switching:
- decoded = a_s >= ROM_BASE.
- rom_addr = a_s - ROM_BASE, zero-extended to ADDR_W.

Reset
REQ-014 While rst_n=0 at a clk edge:
- FSM = IDLE.
- d_oe=0, buf_oe=1, buf_dir=1, rom_rd=0, act=0.
- d_out=8'hFF, bank=0.
- Sync flops: phi2=0, rw=1, halt=1, a=0, d=0.
REQ-015 Reset asserted in DRIVE SHALL release the bus on the same edge; no drive SHALL occur until 3 clks after want is seen post-reset.

Configuration
REQ-016 Macro BANKSWITCH_EN, when defined, SHALL add SuperGame-style banking:
- decoded = a_s >= 16'h8000.
- $8000-$BFFF maps to rom_addr = bank*16384 + a_s[13:0].
- $C000-$FFFF maps to the last bank: (2^BANK_BITS-1)*16384 + a_s[13:0].
REQ-017 With BANKSWITCH_EN, on a phi2_s falling edge with halt_s=1, rw_s=0 and a_s in $8000-$BFFF, bank SHALL load d_in_s[BANK_BITS-1:0]; writes never drive the bus.
REQ-018 Without BANKSWITCH_EN, bank SHALL be constant 0 and writes SHALL be ignored.

Verification
REQ-019 Scenarios the bench SHALL cover:
- Read, no macro: rst, then phi2=1, halt=1, rw=1, a=$4000; ROM[0]=$A5 -> rom_addr=0, d_out=$A5, d_oe=1 at exactly SYNC_STAGES+3 clks; act one pulse.
- DMA burst: halt=0, a steps $4000->$4001 every 8 clks -> d_oe stays 1, d_out switches $A5->ROM[1], never glitches to Z.
- Out of range: ROM_DEPTH=1024, a=$4400 -> rom_rd never asserts, d_out=$FF driven.
- Bankswitch (BANKSWITCH_EN): write $05 to $8000 on phi2 fall -> bank=5; read $8010 -> rom_addr=$14010; read $C000 -> rom_addr=$1C000.
- Release/reset: drop rw to 0 while in DRIVE -> d_oe=0, buf_oe=1 next clk, buf_dir=0 only after; rst_n=0 in DRIVE -> d_oe=0 on the same edge.
